// File: rtl/wishbone_mailbox.sv
// wishbone_mailbox: classic Wishbone slave that gives the CPU a mailbox channel.
//   Bus writes to DATA push the TX FIFO, which drains onto the tx stream. The rx stream
//   fills the RX FIFO, and bus reads of DATA pop it. A level-sensitive irq reports
//   RX not empty and/or TX empty, each gated by its own enable.
// Ports:
//   sys_clk, sys_rst_n          clock (rising edge), asynchronous active-low reset
//   wb_cyc/stb/we/tag/sel/adr   bus request (tag ignored, only adr[3:2] decoded)
//   wb_mosi / wb_miso           write data / read data (miso valid with ack)
//   wb_ack / wb_err             one-cycle response, mutually exclusive
//   tx_valid/tx_data/tx_ready   outgoing stream, head of TX FIFO
//   rx_valid/rx_data/rx_ready   incoming stream into RX FIFO
//   irq                         (ie_rx & !rx_empty) | (ie_tx & tx_empty)
// Register map (adr[3:2]): 0 DATA, 1 STAT (RO), 2 CTRL, 3 reserved (err).
// Assumes DW >= 24 so the STAT fields fit, and DEPTH <= 128 so levels fit 8 bits.
module wishbone_mailbox #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32,
  parameter int unsigned TW    = 3,
  parameter int unsigned SW    = DW / 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          wb_cyc,
  input  logic          wb_stb,
  input  logic          wb_we,
  input  logic [TW-1:0] wb_tag,
  input  logic [SW-1:0] wb_sel,
  input  logic [AW-1:0] wb_adr,
  input  logic [DW-1:0] wb_mosi,
  output logic [DW-1:0] wb_miso,
  output logic          wb_ack,
  output logic          wb_err,
  output logic          tx_valid,
  output logic [DW-1:0] tx_data,
  input  logic          tx_ready,
  input  logic          rx_valid,
  input  logic [DW-1:0] rx_data,
  output logic          rx_ready,
  output logic          irq
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] FullLvl = LW'(DEPTH);

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e        state_q, state_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [DW-1:0] miso_q, miso_d;
  logic          ie_rx_q, ie_rx_d;
  logic          ie_tx_q, ie_tx_d;

  // TX FIFO
  logic [DW-1:0] tx_mem [DEPTH];
  logic [PW-1:0] tx_wr_q, tx_rd_q;
  logic [LW-1:0] tx_cnt_q;
  logic          tx_empty, tx_full, tx_push, tx_pop, tx_flush;

  // RX FIFO
  logic [DW-1:0] rx_mem [DEPTH];
  logic [PW-1:0] rx_wr_q, rx_rd_q;
  logic [LW-1:0] rx_cnt_q;
  logic          rx_empty, rx_full, rx_push, rx_pop, rx_flush;

  logic          sel_all;
  logic [31:0]   stat_word;

  // Tag, undecoded address bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{wb_tag, wb_adr[AW-1:4], wb_adr[1:0]};

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == FullLvl);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FullLvl);

  // Stream handshakes depend on FIFO state only.
  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_mem[tx_rd_q];
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_ready = ~rx_full;
  assign rx_push  = rx_valid & rx_ready;

  assign sel_all   = (wb_sel == {SW{1'b1}});
  assign stat_word = {8'h00, 8'(tx_cnt_q), 8'(rx_cnt_q), 4'h0,
                      tx_full, tx_empty, rx_full, rx_empty};

  assign wb_ack  = ack_q;
  assign wb_err  = err_q;
  assign wb_miso = miso_q;
  assign irq     = (ie_rx_q & ~rx_empty) | (ie_tx_q & tx_empty);

  // Bus FSM: a request seen in StIdle is executed on that edge; StResp presents it.
  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    miso_d   = '0;
    ie_rx_d  = ie_rx_q;
    ie_tx_d  = ie_tx_q;
    tx_push  = 1'b0;
    rx_pop   = 1'b0;
    tx_flush = 1'b0;
    rx_flush = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wb_cyc && wb_stb) begin
          state_d = StResp;
          case (wb_adr[3:2])
            2'd0: begin
              if (wb_we) begin
                if (!sel_all || tx_full) begin
                  err_d = 1'b1;
                end else begin
                  ack_d   = 1'b1;
                  tx_push = 1'b1;
                end
              end else begin
                if (rx_empty) begin
                  err_d = 1'b1;
                end else begin
                  ack_d  = 1'b1;
                  miso_d = rx_mem[rx_rd_q];
                  rx_pop = 1'b1;
                end
              end
            end
            2'd1: begin
              ack_d = 1'b1;
              if (!wb_we) miso_d = DW'(stat_word);
            end
            2'd2: begin
              ack_d = 1'b1;
              if (wb_we) begin
                // All CTRL bits live in byte 0, so sel[0] gates the flushes too.
                if (wb_sel[0]) begin
                  ie_rx_d  = wb_mosi[0];
                  ie_tx_d  = wb_mosi[1];
                  tx_flush = wb_mosi[2];
                  rx_flush = wb_mosi[3];
                end
              end else begin
                miso_d = DW'({ie_tx_q, ie_rx_q});
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      miso_q  <= '0;
      ie_rx_q <= 1'b0;
      ie_tx_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      miso_q  <= miso_d;
      ie_rx_q <= ie_rx_d;
      ie_tx_q <= ie_tx_d;
    end
  end

  // TX FIFO pointers/level; flush overrides any same-edge transfer.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else if (tx_flush) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + PW'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + PW'(1);
      if (tx_push && !tx_pop) begin
        tx_cnt_q <= tx_cnt_q + LW'(1);
      end else if (tx_pop && !tx_push) begin
        tx_cnt_q <= tx_cnt_q - LW'(1);
      end
    end
  end

  // RX FIFO pointers/level; flush overrides any same-edge transfer.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else if (rx_flush) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + PW'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + PW'(1);
      if (rx_push && !rx_pop) begin
        rx_cnt_q <= rx_cnt_q + LW'(1);
      end else if (rx_pop && !rx_push) begin
        rx_cnt_q <= rx_cnt_q - LW'(1);
      end
    end
  end

  // Storage needs no reset; pointers define which entries are live.
  always_ff @(posedge sys_clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= wb_mosi;
    if (rx_push) rx_mem[rx_wr_q] <= rx_data;
  end

endmodule

// File: tb/tb_wishbone_mailbox.sv
// Self-checking bench for wishbone_mailbox: directed scenarios followed by randomized
// bus/stream traffic, checked against a queue-based reference model.
module tb_wishbone_mailbox;

  localparam int DEPTH = 8;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        wb_cyc, wb_stb, wb_we;
  logic [2:0]  wb_tag;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_mosi, wb_miso;
  logic        wb_ack, wb_err;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;
  logic [31:0] tx_data, rx_data;

  wishbone_mailbox dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .wb_cyc   (wb_cyc),
    .wb_stb   (wb_stb),
    .wb_we    (wb_we),
    .wb_tag   (wb_tag),
    .wb_sel   (wb_sel),
    .wb_adr   (wb_adr),
    .wb_mosi  (wb_mosi),
    .wb_miso  (wb_miso),
    .wb_ack   (wb_ack),
    .wb_err   (wb_err),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .irq      (irq)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model
  logic [31:0] txq[$];
  logic [31:0] rxq[$];
  bit          m_ie_rx, m_ie_tx;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic post_chk(input string tag);
    chk({tag, "_tx_valid"}, tx_valid, txq.size() != 0);
    chk({tag, "_rx_ready"}, rx_ready, rxq.size() != DEPTH);
    chk({tag, "_irq"}, irq, (m_ie_rx && rxq.size() != 0) || (m_ie_tx && txq.size() == 0));
    if (txq.size() != 0) chk({tag, "_tx_data"}, tx_data, txq[0]);
  endtask

  // One bus access; optional stream activity on the accepting edge only.
  task automatic access(input logic we, input logic [1:0] rg, input logic [31:0] d,
                        input logic [3:0] sel, input logic txr, input logic rxv,
                        input logic [31:0] rxd, output logic a, output logic e,
                        output logic [31:0] q);
    bit          exp_ack, exp_err, bus_push, bus_pop, txf, rxf;
    logic [31:0] exp_q;
    int          ts, rs;
    @(negedge sys_clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_sel = sel; wb_mosi = d;
    wb_adr = $urandom(); wb_adr[3:2] = rg; wb_tag = 3'($urandom());
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    ts = txq.size(); rs = rxq.size();
    if (ts != 0) chk("acc_pre_tx_data", tx_data, txq[0]);
    exp_ack = 0; exp_err = 0; exp_q = 0; bus_push = 0; bus_pop = 0; txf = 0; rxf = 0;
    case (rg)
      2'd0: begin
        if (we) begin
          if (sel != 4'hF || ts == DEPTH) exp_err = 1;
          else begin exp_ack = 1; bus_push = 1; end
        end else begin
          if (rs == 0) exp_err = 1;
          else begin exp_ack = 1; exp_q = rxq[0]; bus_pop = 1; end
        end
      end
      2'd1: begin
        exp_ack = 1;
        if (!we) exp_q = {8'h00, 8'(ts), 8'(rs), 4'h0,
                          ts == DEPTH, ts == 0, rs == DEPTH, rs == 0};
      end
      2'd2: begin
        exp_ack = 1;
        if (!we) exp_q = {30'h0, m_ie_tx, m_ie_rx};
        else if (sel[0]) begin
          m_ie_rx = d[0]; m_ie_tx = d[1]; txf = d[2]; rxf = d[3];
        end
      end
      default: exp_err = 1;
    endcase
    // Full/empty judged on pre-edge sizes; flush wins over everything.
    if (txr && ts > 0) void'(txq.pop_front());
    if (bus_push) txq.push_back(d);
    if (bus_pop) void'(rxq.pop_front());
    if (rxv && rs < DEPTH) rxq.push_back(rxd);
    if (txf) txq.delete();
    if (rxf) rxq.delete();
    @(posedge sys_clk);
    #1;
    a = wb_ack; e = wb_err; q = wb_miso;
    chk("acc_ack", wb_ack, exp_ack);
    chk("acc_err", wb_err, exp_err);
    chk("acc_miso", wb_miso, exp_q);
    post_chk("acc_post");
    wb_cyc = 1'b0; wb_stb = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
    @(posedge sys_clk);
    #1;
    chk("acc_resp_one_cycle", {30'h0, wb_ack, wb_err}, 32'h0);
  endtask

  // One cycle of stream activity with the bus idle.
  task automatic stream(input logic txr, input logic rxv, input logic [31:0] rxd);
    int ts, rs;
    @(negedge sys_clk);
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    ts = txq.size(); rs = rxq.size();
    post_chk("str_pre");
    if (txr && ts > 0) void'(txq.pop_front());
    if (rxv && rs < DEPTH) rxq.push_back(rxd);
    @(posedge sys_clk);
    #1;
    post_chk("str_post");
    tx_ready = 1'b0; rx_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        a, e;
    logic [31:0] q;
    logic [31:0] w[3];
    int          op, ptx, prx;

    sys_rst_n = 1'b0;
    wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_tag = 0; wb_sel = 0; wb_adr = 0; wb_mosi = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0;
    m_ie_rx = 0; m_ie_tx = 0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_ack", wb_ack, 0);
    chk("rst_err", wb_err, 0);
    chk("rst_miso", wb_miso, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_irq", irq, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // 1: STAT after reset
    access(0, 2'd1, 0, 4'hF, 0, 0, 0, a, e, q);
    chk("t1_ack", a, 1);
    chk("t1_stat", q, 32'h0000_0005);

    // 2: single write
    access(1, 2'd0, 32'hA5A5_A5A5, 4'hF, 0, 0, 0, a, e, q);
    chk("t2_ack", a, 1);
    chk("t2_tx_data", tx_data, 32'hA5A5_A5A5);
    access(0, 2'd1, 0, 4'hF, 0, 0, 0, a, e, q);
    chk("t2_stat", q, 32'h0001_0001);

    // 3: fill TX, overflow errs, full+pop still errs, drain in order
    for (int i = 0; i < 7; i++) access(1, 2'd0, $urandom(), 4'hF, 0, 0, 0, a, e, q);
    access(1, 2'd0, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, a, e, q);
    chk("t3_full_err", e, 1);
    access(0, 2'd1, 0, 4'hF, 0, 0, 0, a, e, q);
    chk("t3_stat_full", q, 32'h0008_0009);
    access(1, 2'd0, 32'h1111_2222, 4'hF, 1, 0, 0, a, e, q);
    chk("t3_full_pop_err", e, 1);
    for (int i = 0; i < 8; i++) stream(1, 0, 0);
    chk("t3_drained", tx_valid, 0);

    // 4: three RX words, four reads
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom();
      stream(0, 1, w[i]);
    end
    for (int i = 0; i < 3; i++) begin
      access(0, 2'd0, 0, 4'hF, 0, 0, 0, a, e, q);
      chk("t4_rd_data", q, w[i]);
    end
    access(0, 2'd0, 0, 4'hF, 0, 0, 0, a, e, q);
    chk("t4_empty_err", e, 1);
    chk("t4_empty_miso", q, 0);

    // 5: RX irq
    access(1, 2'd2, 32'h1, 4'hF, 0, 0, 0, a, e, q);
    chk("t5_irq_idle", irq, 0);
    stream(0, 1, 32'h5A5A_0001);
    chk("t5_irq_set", irq, 1);
    access(0, 2'd0, 0, 4'hF, 0, 0, 0, a, e, q);
    chk("t5_irq_clr", irq, 0);

    // 6: flush full RX with rx_valid held, then reset mid-response
    for (int i = 0; i < DEPTH; i++) stream(0, 1, $urandom());
    chk("t6_rx_full", rx_ready, 0);
    access(1, 2'd2, 32'h8, 4'hF, 0, 1, $urandom(), a, e, q);
    chk("t6_flush_ack", a, 1);
    chk("t6_rx_ready", rx_ready, 1);
    access(0, 2'd1, 0, 4'hF, 0, 0, 0, a, e, q);
    chk("t6_stat", q, 32'h0000_0005);
    access(1, 2'd0, 32'h0000_1234, 4'hF, 0, 0, 0, a, e, q);
    @(negedge sys_clk);
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h4; wb_sel = 4'hF;
    @(posedge sys_clk);
    #1;
    chk("t6_resp_ack", wb_ack, 1);
    wb_cyc = 0; wb_stb = 0;
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("t6_rst_ack", wb_ack, 0);
    chk("t6_rst_tx_valid", tx_valid, 0);
    chk("t6_rst_rx_ready", rx_ready, 1);
    txq.delete(); rxq.delete(); m_ie_rx = 0; m_ie_tx = 0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    access(0, 2'd1, 0, 4'hF, 0, 0, 0, a, e, q);
    chk("t6_post_rst_stat", q, 32'h0000_0005);

    // Randomized traffic; stream bias flips halfway to reach both full and empty.
    for (int i = 0; i < 400; i++) begin
      ptx = (i < 200) ? 15 : 65;
      prx = (i < 200) ? 55 : 20;
      op = $urandom_range(0, 9);
      if (op < 4) begin
        stream($urandom_range(0, 99) < ptx, $urandom_range(0, 99) < prx, $urandom());
      end else begin
        logic        we;
        logic [1:0]  rg;
        logic [31:0] d;
        logic [3:0]  sel;
        sel = ($urandom_range(0, 7) == 0) ? 4'($urandom()) : 4'hF;
        d   = $urandom();
        case (op)
          4:       begin we = 1; rg = 2'd0; end
          5:       begin we = 0; rg = 2'd0; end
          6:       begin we = 1'($urandom()); rg = 2'd1; end
          7: begin
            we = 1; rg = 2'd2;
            d = d & 32'hFFFF_FFF3;
            if ($urandom_range(0, 15) == 0) d[2] = 1'b1;
            if ($urandom_range(0, 15) == 0) d[3] = 1'b1;
          end
          8:       begin we = 0; rg = 2'd2; end
          default: begin we = 1'($urandom()); rg = 2'd3; end
        endcase
        access(we, rg, d, sel, $urandom_range(0, 99) < ptx, $urandom_range(0, 99) < prx,
               $urandom(), a, e, q);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
